// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - single BRAM port shared by a display prefetch FIFO and a codec
// Display wins while its FIFO is nearly drained; otherwise the codec has priority.
module fb_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 8,
  parameter int FB_PIXELS  = 307200,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_en,
  input  logic              disp_frame_start,
  input  logic              disp_pop,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_empty,
  output logic              disp_underflow,
  input  logic              codec_req,
  input  logic              codec_we,
  input  logic [ADDR_W-1:0] codec_addr,
  input  logic [DATA_W-1:0] codec_wdata,
  output logic              codec_gnt,
  output logic              codec_rvalid,
  output logic [DATA_W-1:0] codec_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_idx;
  logic [PW-1:0]     wr_idx;
  logic [CW-1:0]     count;
  logic [CW-1:0]     level;
  logic [ADDR_W-1:0] ptr;
  logic              tag_valid;
  logic              tag_disp;
  logic              underflow_q;
  logic              disp_elig;
  logic              disp_urgent;
  logic              grant_disp;
  logic              grant_codec;
  logic              push;
  logic              pop_ok;

  // Level counts the read already in flight so the FIFO can never overfill.
  assign level = count + CW'(tag_valid & tag_disp);

  always_comb begin
    disp_elig   = rst & disp_en & (level < CW'(FIFO_DEPTH)) & ~disp_frame_start;
    disp_urgent = disp_elig & (level < CW'(LOW_WM));
    grant_codec = rst & codec_req & ~disp_urgent;
    grant_disp  = disp_elig & ~grant_codec;
  end

  always_comb begin
    mem_en    = grant_disp | grant_codec;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    codec_gnt = grant_codec;
    if (grant_codec) begin
      mem_we   = codec_we;
      mem_addr = codec_addr;
      mem_din  = codec_wdata;
    end else if (grant_disp) begin
      mem_addr = ptr;
    end
  end

  assign push   = tag_valid & tag_disp & ~disp_frame_start;
  assign pop_ok = disp_pop & ~disp_frame_start & (count != '0);

  assign disp_empty     = (count == '0);
  assign disp_data      = disp_empty ? '0 : fifo_mem[rd_idx];
  assign disp_underflow = underflow_q;
  assign codec_rvalid   = tag_valid & ~tag_disp;
  assign codec_rdata    = codec_rvalid ? mem_dout : '0;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_idx] <= mem_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_idx      <= '0;
      wr_idx      <= '0;
      count       <= '0;
      ptr         <= '0;
      tag_valid   <= 1'b0;
      tag_disp    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (disp_frame_start) begin
        rd_idx <= '0;
        wr_idx <= '0;
        count  <= '0;
        ptr    <= '0;
      end else begin
        if (push)   wr_idx <= wr_idx + 1'b1;
        if (pop_ok) rd_idx <= rd_idx + 1'b1;
        count <= count + CW'(push) - CW'(pop_ok);
        if (disp_pop && count == '0) underflow_q <= 1'b1;
        if (grant_disp) ptr <= (ptr == ADDR_W'(FB_PIXELS - 1)) ? '0 : ptr + 1'b1;
      end
      // A codec write returns nothing, so only reads occupy the tag.
      tag_valid <= grant_disp | (grant_codec & ~codec_we);
      tag_disp  <= grant_disp;
    end
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 19, frame-buffer address width; DATA_W, default 8, pixel width; FB_PIXELS, default 307200, display wrap point; FIFO_DEPTH, default 16, display prefetch depth, a power of 2; LOW_WM, default 4, display urgency threshold.
REQ-002 clk  in  1  single clock for all logic; the BRAM port is clocked by this clock.
REQ-003 rst  in  1  reset, asynchronous assert, active-low.
REQ-004 disp_en  in  1  enables display prefetch.
REQ-005 disp_frame_start  in  1  one-cycle pulse: restart the display stream at address 0.
REQ-006 disp_pop  in  1  consume the FIFO head pixel.
REQ-007 disp_data  out  DATA_W  FIFO head pixel, show-ahead; disp_empty  out  1  FIFO empty; disp_underflow  out  1  sticky pop-on-empty flag.
REQ-008 codec_req  in  1, codec_we  in  1, codec_addr  in  ADDR_W, codec_wdata  in  DATA_W: codec access request, held stable until granted.
REQ-009 codec_gnt  out  1  request accepted this cycle; codec_rvalid  out  1, codec_rdata  out  DATA_W: read return.
REQ-010 mem_en  out  1, mem_we  out  1, mem_addr  out  ADDR_W, mem_din  out  DATA_W, mem_dout  in  DATA_W: the single shared BRAM port, with read latency 1.

Function
REQ-011 Exactly one access SHALL be issued per cycle at most; mem_*, codec_gnt SHALL be combinational from the current-cycle decision.
REQ-012 level = FIFO count + in-flight display reads; display-eligible = disp_en & level < FIFO_DEPTH & !disp_frame_start.
REQ-013 Priority SHALL be: (1) display if eligible and level < LOW_WM; (2) codec if codec_req; (3) display if eligible; (4) idle with mem_en=0.
REQ-014 A codec grant SHALL drive mem_we=codec_we, mem_addr=codec_addr, mem_din=codec_wdata, codec_gnt=1.
REQ-015 A display grant SHALL drive mem_we=0, mem_addr=display pointer; the pointer SHALL then increment, wrapping FB_PIXELS-1 -> 0.
REQ-016 A one-entry source tag SHALL track each read; on the next cycle mem_dout SHALL go to the FIFO (display) or to codec_rdata with codec_rvalid=1 for exactly one cycle (codec).
REQ-017 Codec write grants SHALL produce no rvalid; codec read latency SHALL be grant +1 cycle.
REQ-018 disp_pop with !disp_empty SHALL remove the head; a pop and a push in the same cycle SHALL leave the count unchanged.
REQ-019 disp_pop with disp_empty SHALL be ignored and SHALL set disp_underflow, held until reset.
REQ-020 disp_frame_start SHALL flush the FIFO, set the pointer to 0, discard any in-flight display return, and block display grants that cycle; a simultaneous pop SHALL be ignored without setting underflow.
REQ-021 disp_en=0 SHALL stop new display fetches; the FIFO contents, pointer, and in-flight return SHALL be retained.
REQ-022 A codec request SHALL never be starved while level >= LOW_WM.

Reset
REQ-023 While rst=0: FIFO empty, pointer 0, tag cleared, disp_empty=1, disp_data=0, disp_underflow=0, codec_gnt=0, codec_rvalid=0, codec_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-024 Reset mid-access SHALL drop any in-flight read; no rvalid and no FIFO push SHALL occur after release.

Verification
REQ-025 Reset release, disp_en=1, no codec request -> reads at addresses 0..15 on consecutive cycles, disp_empty=0 from cycle 2, fetches stop at level 16.
REQ-026 FIFO full, codec read at address 0x100 (data 0xA5) -> codec_gnt same cycle, codec_rvalid=1 with codec_rdata=0xA5 next cycle.
REQ-027 FIFO level 3, codec_req held -> display wins until level 4, then codec is granted.
REQ-028 Pointer at 307199, fetch -> next mem_addr = 0.
REQ-029 disp_frame_start while a display read is in flight -> FIFO empty next cycle, stale data not pushed, next display fetch at address 0.
REQ-030 disp_pop on empty -> disp_underflow=1 and count stays 0; flag holds until rst=0.
